// File: rtl/clb_switch_box_cfg.sv
// CLB switch box with single/double-length routing and a serial, daisy-chainable config chain.
// Optional trailing even-parity check on each frame: define CFG_PARITY_EN.
module clb_switch_box_cfg #(
   parameter int WS = 8,
   parameter int WD = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   inout  wire [WS-1:0]  north_single,
   inout  wire [WS-1:0]  east_single,
   inout  wire [WS-1:0]  south_single,
   inout  wire [WS-1:0]  west_single,
   inout  wire [WD-1:0]  north_double,
   inout  wire [WD-1:0]  east_double,
   inout  wire [WD-1:0]  south_double,
   inout  wire [WD-1:0]  west_double,
   input  logic          cfg_en,
   input  logic          cfg_in,
   output logic          cfg_out,
   output logic          cfg_done,
   output logic          cfg_err
);

   localparam int WH   = WD / 2;
   localparam int NCFG = (WS + WH) * 6;
`ifdef CFG_PARITY_EN
   localparam int FRAME = NCFG + 1;
`else
   localparam int FRAME = NCFG;
`endif
   localparam int CW = $clog2(NCFG + 2);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SHIFT  = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]      state;
   logic [CW-1:0]   count;
   logic [NCFG-1:0] shadow;
   logic [NCFG-1:0] active;

`ifdef CFG_PARITY_EN
   logic par;
   logic err_q;
   logic par_bit;
   // The trailing parity bit only feeds the running XOR; the shadow holds data bits only.
   assign par_bit = (state == S_SHIFT) && (count == CW'(NCFG));
   assign cfg_err = err_q;
`else
   assign cfg_err = 1'b0;
`endif

   assign cfg_out = shadow[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         count    <= '0;
         shadow   <= '0;
         active   <= '0;
         cfg_done <= 1'b0;
`ifdef CFG_PARITY_EN
         par      <= 1'b0;
         err_q    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: if (cfg_en) begin
               shadow   <= {cfg_in, shadow[NCFG-1:1]};
               count    <= CW'(1);
               cfg_done <= 1'b0;
`ifdef CFG_PARITY_EN
               par      <= cfg_in;
               err_q    <= 1'b0;
`endif
               state    <= S_SHIFT;
            end
            S_SHIFT: if (cfg_en) begin
`ifdef CFG_PARITY_EN
               if (!par_bit) shadow <= {cfg_in, shadow[NCFG-1:1]};
               par <= par ^ cfg_in;
`else
               shadow <= {cfg_in, shadow[NCFG-1:1]};
`endif
               count <= count + 1'b1;
               if (count == CW'(FRAME - 1)) state <= S_COMMIT;
            end else begin
               // Abort: partial shadow is kept, active is untouched.
               state <= S_IDLE;
               count <= '0;
            end
            S_COMMIT: begin
               count <= '0;
               state <= S_IDLE;
`ifdef CFG_PARITY_EN
               if (par) begin
                  err_q <= 1'b1;
               end else begin
                  active   <= shadow;
                  cfg_done <= 1'b1;
               end
`else
               active   <= shadow;
               cfg_done <= 1'b1;
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Per-track c order: [0] N-S, [1] E-W, [2] N-E, [3] E-S, [4] S-W, [5] W-N.
   for (genvar i = 0; i < WS; i++) begin : g_single
      logic [5:0] c;
      assign c = active[6*i +: 6];
      assign north_single[i] = c[0] ? south_single[i] : 1'bz;
      assign south_single[i] = c[0] ? north_single[i] : 1'bz;
      assign east_single[i]  = c[1] ? west_single[i]  : 1'bz;
      assign west_single[i]  = c[1] ? east_single[i]  : 1'bz;
      assign north_single[i] = c[2] ? east_single[i]  : 1'bz;
      assign east_single[i]  = c[2] ? north_single[i] : 1'bz;
      assign east_single[i]  = c[3] ? south_single[i] : 1'bz;
      assign south_single[i] = c[3] ? east_single[i]  : 1'bz;
      assign south_single[i] = c[4] ? west_single[i]  : 1'bz;
      assign west_single[i]  = c[4] ? south_single[i] : 1'bz;
      assign west_single[i]  = c[5] ? north_single[i] : 1'bz;
      assign north_single[i] = c[5] ? west_single[i]  : 1'bz;
   end

   // Double box uses N/W low halves and E/S high halves; the other halves pass straight through.
   for (genvar i = 0; i < WH; i++) begin : g_double
      logic [5:0] c;
      assign c = active[WS*6 + 6*i +: 6];
      assign north_double[i]    = c[0] ? south_double[i+WH] : 1'bz;
      assign south_double[i+WH] = c[0] ? north_double[i]    : 1'bz;
      assign east_double[i+WH]  = c[1] ? west_double[i]     : 1'bz;
      assign west_double[i]     = c[1] ? east_double[i+WH]  : 1'bz;
      assign north_double[i]    = c[2] ? east_double[i+WH]  : 1'bz;
      assign east_double[i+WH]  = c[2] ? north_double[i]    : 1'bz;
      assign east_double[i+WH]  = c[3] ? south_double[i+WH] : 1'bz;
      assign south_double[i+WH] = c[3] ? east_double[i+WH]  : 1'bz;
      assign south_double[i+WH] = c[4] ? west_double[i]     : 1'bz;
      assign west_double[i]     = c[4] ? south_double[i+WH] : 1'bz;
      assign west_double[i]     = c[5] ? north_double[i]    : 1'bz;
      assign north_double[i]    = c[5] ? west_double[i]     : 1'bz;
      assign north_double[i+WH] = south_double[i];
      assign east_double[i]     = west_double[i+WH];
   end

endmodule

// File: tb/tb_clb_switch_box_cfg.sv
// Directed bench for clb_switch_box_cfg: reset, commit latency, abort, daisy chain, async reset, parity.
module tb_clb_switch_box_cfg;
   localparam int WS = 8, WD = 8, WH = WD / 2, NCFG = (WS + WH) * 6;
`ifdef CFG_PARITY_EN
   localparam int FRAME = NCFG + 1;
   localparam bit PAR = 1'b1;
`else
   localparam int FRAME = NCFG;
   localparam bit PAR = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0, cfg_en = 1'b0, cfg_in = 1'b0, chain = 1'b0;
   always #5 clk = ~clk;

   tri0 [WS-1:0] ns, es, ss, ws, ns2, es2, ss2, ws2;
   tri0 [WD-1:0] nd, ed, sd, wd, nd2, ed2, sd2, wd2;
   logic cfg_out, cfg_done, cfg_err, out2, done2, err2;
   logic d_ns = 0, d_ss = 0, d_es = 0, d_nd = 0, d_sd = 0, d2_ns = 0, d2_nd = 0;

   assign ns[0]  = d_ns  ? 1'b1 : 1'bz;
   assign ss[0]  = d_ss  ? 1'b1 : 1'bz;
   assign es[0]  = d_es  ? 1'b1 : 1'bz;
   assign nd[0]  = d_nd  ? 1'b1 : 1'bz;
   assign sd[0]  = d_sd  ? 1'b1 : 1'bz;
   assign ns2[0] = d2_ns ? 1'b1 : 1'bz;
   assign nd2[0] = d2_nd ? 1'b1 : 1'bz;

   clb_switch_box_cfg #(.WS(WS), .WD(WD)) u_up (
      .clk(clk), .rst_n(rst_n),
      .north_single(ns), .east_single(es), .south_single(ss), .west_single(ws),
      .north_double(nd), .east_double(ed), .south_double(sd), .west_double(wd),
      .cfg_en(cfg_en), .cfg_in(cfg_in), .cfg_out(cfg_out), .cfg_done(cfg_done), .cfg_err(cfg_err));

   clb_switch_box_cfg #(.WS(WS), .WD(WD)) u_dn (
      .clk(clk), .rst_n(rst_n),
      .north_single(ns2), .east_single(es2), .south_single(ss2), .west_single(ws2),
      .north_double(nd2), .east_double(ed2), .south_double(sd2), .west_double(wd2),
      .cfg_en(cfg_en & chain), .cfg_in(cfg_out), .cfg_out(out2), .cfg_done(done2), .cfg_err(err2));

   int errs = 0, checks = 0;

   task automatic chk(input string tag, input logic [NCFG-1:0] got, input logic [NCFG-1:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bits sent on successive negedges; returns at the negedge after the last bit is sampled.
   task automatic send(input logic [NCFG:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cfg_en = 1'b1;
         cfg_in = f[i];
      end
      @(negedge clk);
      cfg_en = 1'b0;
      cfg_in = 1'b0;
   endtask

   task automatic commit_chk(input string tag, input logic done_exp, input logic err_exp);
      chk({tag, "_done_1cyc"}, cfg_done, 0);
      @(negedge clk);
      chk({tag, "_done_2cyc"}, cfg_done, done_exp);
      chk({tag, "_err"}, cfg_err, err_exp);
   endtask

   logic [NCFG:0]   fa, fb, fc, fz, fbad;
   logic [NCFG-1:0] oa;

   initial begin
      // fa: N0-S0, W0-N0, double N0-S0. fb: N0-S0, N0-E0. fc: E0-W0, W0-N0.
      fa = '0; fa[0] = 1; fa[5] = 1; fa[WS*6] = 1; fa[NCFG] = ^fa[NCFG-1:0];
      fb = '0; fb[0] = 1; fb[2] = 1;               fb[NCFG] = ^fb[NCFG-1:0];
      fc = '0; fc[1] = 1; fc[5] = 1;               fc[NCFG] = ^fc[NCFG-1:0];
      fz = '0;
      fbad = fa; fbad[NCFG] = ~fa[NCFG];
      oa = '0;

      repeat (3) @(negedge clk);
      chk("rst_done", cfg_done, 0);
      chk("rst_err", cfg_err, 0);
      chk("rst_out", cfg_out, 0);
      rst_n = 1'b1;
      @(negedge clk);
      d_ss = 1; #1; chk("rst_single_open", ns[0], 0); d_ss = 0;
      d_sd = 1; #1; chk("rst_passthru", nd[WH], 1); d_sd = 0;
      d_nd = 1; #1; chk("rst_double_open", sd[WH], 0); d_nd = 0;

      send(fa, FRAME);
      commit_chk("fa", 1, 0);
      d_ns = 1; #1;
      chk("fa_n_to_s", ss[0], 1);
      chk("fa_n_to_w", ws[0], 1);
      chk("fa_e_open", es[0], 0);
      d_ns = 0;
      d_nd = 1; #1; chk("fa_double", sd[WH], 1); d_nd = 0;

      send(fz, NCFG / 2);
      repeat (3) @(negedge clk);
      chk("abort_done", cfg_done, 0);
      d_ns = 1; #1; chk("abort_keep", ss[0], 1); d_ns = 0;

      send(fc, FRAME);
      commit_chk("fc", 1, 0);
      d_es = 1; #1;
      chk("fc_e_to_w", ws[0], 1);
      chk("fc_e_to_n", ns[0], 1);
      chk("fc_s_open", ss[0], 0);
      d_es = 0;

      // Async reset part way into a frame: cfg_out shows fc[5] after 5 shifts.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         cfg_en = 1'b1;
         cfg_in = 1'b0;
      end
      @(negedge clk);
      chk("mid_out_before", cfg_out, fc[5]);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out", cfg_out, 0);
      chk("mid_rst_done", cfg_done, 0);
      chk("mid_rst_err", cfg_err, 0);
      chk("mid_rst_w_open", ws[0], 0);
      chk("mid_rst_n_open", ns[0], 0);
      cfg_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Daisy chain: fa, one ignored COMMIT cycle, then fb, cfg_en high throughout.
      chain = 1'b1;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         cfg_en = 1'b1;
         cfg_in = fa[i];
      end
      @(negedge clk);
      cfg_in = 1'b1;
      @(negedge clk);
      chk("dc_up_done", cfg_done, 1);
      chk("dc_dn_done", done2, PAR ? 1'b0 : 1'b1);
      oa[0] = cfg_out;
      d_ns = 1; #1; chk("dc_up_route", ss[0], 1); d_ns = 0;
      cfg_in = fb[0];
      for (int k = 1; k < FRAME; k++) begin
         @(negedge clk);
         if (k < NCFG) oa[k] = cfg_out;
         cfg_in = fb[k];
      end
      @(negedge clk);
      cfg_en = 1'b0;
      cfg_in = 1'b0;
      chk("dc_stream", oa, fa[NCFG-1:0]);
      @(negedge clk);
      chk("dc_up_done2", cfg_done, 1);
      chk("dc_dn_done2", done2, 1);
      chk("dc_dn_err2", err2, 0);
      d_ns = 1; #1; chk("dc_up_n_to_e", es[0], 1); d_ns = 0;
      d_nd = 1; #1; chk("dc_up_double_open", sd[WH], 0); d_nd = 0;
      d2_ns = 1; #1; chk("dc_dn_route", ss2[0], 1); d2_ns = 0;
      d2_nd = 1; #1; chk("dc_dn_double", sd2[WH], 1); d2_nd = 0;
      chain = 1'b0;
      @(negedge clk);

`ifdef CFG_PARITY_EN
      send(fbad, FRAME);
      commit_chk("par_bad", 0, 1);
      d_nd = 1; #1; chk("par_bad_keep", sd[WH], 0); d_nd = 0;
      send(fa, FRAME);
      commit_chk("par_good", 1, 0);
      d_nd = 1; #1; chk("par_good_double", sd[WH], 1); d_nd = 0;
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
